if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that consumes the PC stream from the PC generator and produces the stage_IF_ready back-pressure that PC generator uses to advance. It issues one outstanding instruction-memory read per accepted PC and tolerates variable response latency. It buffers the returned instruction in a one-entry output register and hands it to decode with a valid/ready handshake. On a jump/branch redirect it discards stale in-flight and buffered fetches.

Parameters:
XLEN, 32, PC/instruction width
TIMEOUT_CYCLES, 16, max cycles after a request before the response is abandoned (>=2)

Ports:
clk_i  in  1  clock, all state updates on posedge
reset_i  in  1  synchronous active-high reset
enable_i  in  1  design enable; 0 blocks new requests, in-flight ones complete
pc_i  in  XLEN  PC from PC generator
pc_valid_i  in  1  pc_i valid
flush_i  in  1  jump|branch redirect this cycle
stage_IF_ready_o  out  1  pc_i accepted this cycle (combinational)
imem_req_o  out  1  memory read request, single-cycle pulse
imem_addr_o  out  XLEN  read address (= pc_i when imem_req_o)
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  XLEN  read data
inst_o  out  XLEN  instruction to decode
inst_pc_o  out  XLEN  PC of inst_o
inst_valid_o  out  1  output register full
id_ready_i  in  1  decode accepts inst_o when inst_valid_o
fetch_err_o  out  1  sticky: a response timed out
fetch_count_o  out  32  instructions delivered to decode (wraps)

Behaviour:
- Reset (reset_i=1 at posedge, priority over all): state=IDLE, inst_valid_o=0, inst_o=0, inst_pc_o=0, fetch_err_o=0, fetch_count_o=0, timeout counter=0; reset mid-WAIT drops the in-flight fetch, and a later imem_rvalid_i is ignored.
- out_free = ~inst_valid_o | id_ready_i.
- States: IDLE, WAIT, DRAIN.
- IDLE: issue = enable_i & pc_valid_i & ~flush_i & out_free. imem_req_o = stage_IF_ready_o = issue; imem_addr_o = pc_i. On issue: req_pc<=pc_i, counter<=0, go WAIT. imem_rvalid_i in IDLE is ignored.
- WAIT: imem_req_o=0, stage_IF_ready_o=0, counter increments each cycle.
  - rvalid & ~flush: inst_o<=imem_rdata_i, inst_pc_o<=req_pc, inst_valid_o<=1, go IDLE. Earliest delivery is 1 cycle after the request; the next request can be issued in the following cycle.
  - rvalid & flush: discard, go IDLE.
  - ~rvalid & flush: go DRAIN.
  - ~rvalid & counter==TIMEOUT_CYCLES-1: fetch_err_o<=1, go IDLE.
- DRAIN: counter keeps incrementing. rvalid: discard, go IDLE. counter==TIMEOUT_CYCLES-1: fetch_err_o<=1, go IDLE.
- Output register:
  - inst_valid_o & id_ready_i clears inst_valid_o unless it is reloaded the same cycle.
  - flush_i clears inst_valid_o (buffered instruction squashed), and flush has priority over load.
  - An accepted transfer (inst_valid_o & id_ready_i & ~flush_i) increments fetch_count_o mod 2^32.
- Issue only when out_free, so at most 1 outstanding + 1 buffered; a response always finds the register free.
- enable_i=0 gates issue only; WAIT/DRAIN and the output handshake continue.
- fetch_err_o clears only on reset.

Test Plan:
- Zero-stall stream: pc 0x100,0x104,0x108 valid, id_ready_i=1, 1-cycle memory -> imem_req every 2nd cycle, inst_pc_o sequence 0x100,0x104,0x108, fetch_count_o=3.
- Decode stall: id_ready_i=0 for 5 cycles after first delivery -> no second request, inst_o/inst_pc_o stable; release -> next request issues the same cycle id_ready_i=1.
- Flush in WAIT with 4-cycle memory latency: flush at cycle 2 -> DRAIN, the late rdata is not delivered, and the next request (pc 0x200) is delivered with inst_pc_o=0x200.
- Flush with rvalid in the same cycle, and flush while inst_valid_o=1 -> inst_valid_o=0 next cycle, fetch_count_o unchanged.
- Timeout: no rvalid for 16 cycles -> fetch_err_o=1 and state IDLE; a stray rvalid afterwards is ignored; reset clears fetch_err_o.
- Reset asserted mid-WAIT and enable_i=0 with pc_valid_i=1 -> all outputs 0, no imem_req_o while disabled.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem read per accepted PC, 1-entry output buffer, flush squash.
// Latency >=1 cycle request->inst_valid_o; stage_IF_ready_o drops while a read is pending or the buffer is held.
module if_fetch_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  input  logic            flush_i,
  output logic            stage_IF_ready_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_valid_o,
  input  logic            id_ready_i,
  output logic            fetch_err_o,
  output logic [31:0]     fetch_count_o
);

  // One spare count value so a flush on the last WAIT cycle can still expire in DRAIN.
  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LP_TLAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_valid;
  logic            r_err;
  logic [31:0]     r_fetch_count;

  logic w_out_free;
  logic w_issue;
  logic w_load;
  logic w_accept;
  logic w_expired;

  assign w_out_free = ~r_inst_valid | id_ready_i;
  // Reset suppresses the request so memory never sees a read that the FSM will forget.
  assign w_issue    = ~reset_i & (r_state == S_IDLE) & enable_i & pc_valid_i
                    & ~flush_i & w_out_free;
  assign w_load     = (r_state == S_WAIT) & imem_rvalid_i & ~flush_i;
  assign w_accept   = r_inst_valid & id_ready_i & ~flush_i;
  assign w_expired  = (r_cnt >= LP_TLAST);

  assign stage_IF_ready_o = w_issue;
  assign imem_req_o       = w_issue;
  assign imem_addr_o      = w_issue ? pc_i : '0;
  assign inst_o           = r_inst;
  assign inst_pc_o        = r_inst_pc;
  assign inst_valid_o     = r_inst_valid;
  assign fetch_err_o      = r_err;
  assign fetch_count_o    = r_fetch_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_req_pc <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_req_pc <= pc_i;
            r_cnt    <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (imem_rvalid_i) begin
            r_state <= S_IDLE;
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          // Stale response is still owed by memory; swallow it or give up on timeout.
          r_cnt <= r_cnt + 1'b1;
          if (imem_rvalid_i) begin
            r_state <= S_IDLE;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output buffer: flush beats load, load beats consume.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_inst        <= '0;
      r_inst_pc     <= '0;
      r_inst_valid  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      if (flush_i) begin
        r_inst_valid <= 1'b0;
      end else if (w_load) begin
        r_inst       <= imem_rdata_i;
        r_inst_pc    <= r_req_pc;
        r_inst_valid <= 1'b1;
      end else if (r_inst_valid & id_ready_i) begin
        r_inst_valid <= 1'b0;
      end
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scenario bench for if_fetch_unit: scoreboard of expected {pc, inst} popped on each decode handshake.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset_i;
  logic        enable_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        flush_i;
  logic        stage_IF_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        id_ready_i;
  logic        fetch_err_o;
  logic [31:0] fetch_count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  if_fetch_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .enable_i         (enable_i),
    .pc_i             (pc_i),
    .pc_valid_i       (pc_valid_i),
    .flush_i          (flush_i),
    .stage_IF_ready_o (stage_IF_ready_o),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_valid_o     (inst_valid_o),
    .id_ready_i       (id_ready_i),
    .fetch_err_o      (fetch_err_o),
    .fetch_count_o    (fetch_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decode-side monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset_i && inst_valid_o && id_ready_i && !flush_i) begin
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_delivery: got pc=%h inst=%h, scoreboard empty", inst_pc_o, inst_o);
      end else begin
        e = sb_q.pop_front();
        if (inst_pc_o !== e.pc || inst_o !== e.inst) begin
          n_fail++;
          $display("FAIL delivery: got pc=%h inst=%h expected pc=%h inst=%h",
                   inst_pc_o, inst_o, e.pc, e.inst);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; enable_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h40;
    flush_i = 1'b0; id_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    repeat (2) cyc();
    #1;
    n_tests++;
    if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_outreg: got v=%b inst=%h pc=%h expected 0/0/0", inst_valid_o, inst_o, inst_pc_o);
    end
    n_tests++;
    if (fetch_err_o !== 1'b0 || fetch_count_o !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_status: got err=%b cnt=%0d expected 0/0", fetch_err_o, fetch_count_o);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (imem_req_o !== 1'b0 || stage_IF_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL disabled_req[%0d]: got req=%b rdy=%b expected 0/0", i, imem_req_o, stage_IF_ready_o);
      end
      cyc();
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    logic [31:0] d;
    enable_i = 1'b1; id_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h100 + 32'(4 * k);
      d  = pc ^ 32'h1357_0000;
      imem_rvalid_i = 1'b0; pc_valid_i = 1'b1; pc_i = pc;
      #1;
      n_tests++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== pc || stage_IF_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_req[%0d]: got req=%b addr=%h expected 1/%h", k, imem_req_o, imem_addr_o, pc);
      end
      cyc();
      pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = d;
      sb_q.push_back('{pc: pc, inst: d});
      pc_valid_i = 1'b1; pc_i = pc + 32'd4;
      #1;
      n_tests++;
      if (imem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_gap[%0d]: got req=%b expected 0", k, imem_req_o);
      end
      pc_valid_i = 1'b0;
      cyc();
    end
    imem_rvalid_i = 1'b0;
    cyc();
    n_tests++;
    if (fetch_count_o !== 32'd3 || inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_count: got cnt=%0d v=%b expected 3/0", fetch_count_o, inst_valid_o);
    end
  endtask

  task automatic test_decode_stall();
    id_ready_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h300;
    cyc();
    pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_0300;
    sb_q.push_back('{pc: 32'h300, inst: 32'hCAFE_0300});
    cyc();
    imem_rvalid_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h304;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== 32'h300 || inst_o !== 32'hCAFE_0300) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h inst=%h expected 0/1/300/cafe0300",
                 i, imem_req_o, inst_valid_o, inst_pc_o, inst_o);
      end
      cyc();
    end
    id_ready_i = 1'b1;
    #1;
    n_tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h304) begin
      n_fail++;
      $display("FAIL stall_release: got req=%b addr=%h expected 1/304", imem_req_o, imem_addr_o);
    end
    cyc();
    pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_0304;
    sb_q.push_back('{pc: 32'h304, inst: 32'hCAFE_0304});
    cyc();
    imem_rvalid_i = 1'b0;
    cyc();
    n_tests++;
    if (fetch_count_o !== 32'd5) begin
      n_fail++;
      $display("FAIL stall_count: got %0d expected 5", fetch_count_o);
    end
  endtask

  task automatic test_flush_wait();
    pc_valid_i = 1'b1; pc_i = 32'h180;
    cyc();
    pc_valid_i = 1'b0;
    cyc();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h200;
    #1;
    n_tests++;
    if (imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_noreq: got req=%b expected 0", imem_req_o);
    end
    cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0180;
    cyc();
    imem_rvalid_i = 1'b0;
    #1;
    n_tests++;
    if (inst_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_discard: got v=%b expected 0", inst_valid_o);
    end
    n_tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      n_fail++;
      $display("FAIL drain_next_req: got req=%b addr=%h expected 1/200", imem_req_o, imem_addr_o);
    end
    cyc();
    pc_valid_i = 1'b0;
    repeat (3) cyc();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h600D_0200;
    sb_q.push_back('{pc: 32'h200, inst: 32'h600D_0200});
    cyc();
    imem_rvalid_i = 1'b0;
    n_tests++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200) begin
      n_fail++;
      $display("FAIL flush_wait_deliver: got v=%b pc=%h expected 1/200", inst_valid_o, inst_pc_o);
    end
    cyc();
    n_tests++;
    if (fetch_count_o !== 32'd6) begin
      n_fail++;
      $display("FAIL flush_wait_count: got %0d expected 6", fetch_count_o);
    end
  endtask

  task automatic test_flush_same_cycle();
    id_ready_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h400;
    cyc();
    pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; flush_i = 1'b1; imem_rdata_i = 32'hBAD0_0400;
    cyc();
    imem_rvalid_i = 1'b0; flush_i = 1'b0;
    n_tests++;
    if (inst_valid_o !== 1'b0 || fetch_count_o !== 32'd6) begin
      n_fail++;
      $display("FAIL flush_rvalid: got v=%b cnt=%0d expected 0/6", inst_valid_o, fetch_count_o);
    end
    id_ready_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h404;
    #1;
    n_tests++;
    if (imem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_rvalid_idle: got req=%b expected 1", imem_req_o);
    end
    cyc();
    pc_valid_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hD00D_0404;
    cyc();
    imem_rvalid_i = 1'b0;
    n_tests++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h404 || inst_o !== 32'hD00D_0404) begin
      n_fail++;
      $display("FAIL buffered_load: got v=%b pc=%h inst=%h expected 1/404/d00d0404",
               inst_valid_o, inst_pc_o, inst_o);
    end
    flush_i = 1'b1; id_ready_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    n_tests++;
    if (inst_valid_o !== 1'b0 || fetch_count_o !== 32'd6) begin
      n_fail++;
      $display("FAIL buffered_squash: got v=%b cnt=%0d expected 0/6", inst_valid_o, fetch_count_o);
    end
  endtask

  task automatic test_timeout();
    pc_valid_i = 1'b1; pc_i = 32'h500;
    cyc();
    pc_valid_i = 1'b0;
    repeat (15) cyc();
    n_tests++;
    if (fetch_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got err=%b expected 0 after 15 wait cycles", fetch_err_o);
    end
    cyc();
    n_tests++;
    if (fetch_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b expected 1 after 16 wait cycles", fetch_err_o);
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0500;
    cyc();
    imem_rvalid_i = 1'b0;
    n_tests++;
    if (inst_valid_o !== 1'b0 || fetch_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_stray: got v=%b err=%b expected 0/1", inst_valid_o, fetch_err_o);
    end
    pc_valid_i = 1'b1; pc_i = 32'h504;
    #1;
    n_tests++;
    if (imem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_idle: got req=%b expected 1", imem_req_o);
    end
    pc_valid_i = 1'b0;
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    n_tests++;
    if (fetch_err_o !== 1'b0 || fetch_count_o !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_reset: got err=%b cnt=%0d expected 0/0", fetch_err_o, fetch_count_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    enable_i = 1'b1; id_ready_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h600;
    cyc();
    pc_valid_i = 1'b0;
    cyc();
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0; enable_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h604;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0600;
    cyc();
    imem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0 || fetch_count_o !== 32'd0 ||
          fetch_err_o !== 1'b0 || imem_req_o !== 1'b0 || stage_IF_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL midwait_reset[%0d]: got v=%b inst=%h pc=%h cnt=%0d err=%b req=%b rdy=%b expected all 0",
                 i, inst_valid_o, inst_o, inst_pc_o, fetch_count_o, fetch_err_o, imem_req_o, stage_IF_ready_o);
      end
      cyc();
    end
    pc_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_decode_stall();
    test_flush_wait();
    test_flush_same_cycle();
    test_timeout();
    test_reset_mid_wait();
    repeat (2) cyc();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d undelivered entries expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
